pop_stack_arbiter: RTL and testbench

- Controller and arbiter for a LIFO stack of 3-bit registers with a parallel shadow bank.
- Arbitrates push, pop and swap requests from two requesters (A, B) using round-robin.
- Sequences the stack storage and returns one response per accepted request.
- Swap exchanges the main and shadow banks entry-by-entry over several cycles, the same way a node's down path moves data to a parallel node.

---
 rtl/pop_stack_arbiter_if.sv | 36 +++
 rtl/pop_stack_arbiter.sv | 177 +++++++++++++++++
 tb/tb_pop_stack_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pop_stack_arbiter_if.sv
// Bundle for two round-robin requesters, the single response port and the stack status.
interface pop_stack_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             a_valid;
  logic [1:0]       a_op;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [1:0]       b_op;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             resp_valid;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;
  logic [CW-1:0]    count;
  logic [CW-1:0]    shadow_count;
  logic             full;
  logic             empty;
  logic             busy;

  modport master (
    output a_valid, a_op, a_data, b_valid, b_op, b_data,
    input  a_ready, b_ready, resp_valid, resp_id, resp_data, resp_err,
           count, shadow_count, full, empty, busy
  );

  modport slave (
    input  a_valid, a_op, a_data, b_valid, b_op, b_data,
    output a_ready, b_ready, resp_valid, resp_id, resp_data, resp_err,
           count, shadow_count, full, empty, busy
  );
endinterface

// File: rtl/pop_stack_arbiter.sv
// Round-robin arbitrated LIFO stack with a shadow bank that is exchanged one entry per cycle.
//   state | meaning
//   IDLE  | accepting requests; push/pop/nop answered on the following cycle
//   SWAP  | exchanging main[idx] with shadow[idx], one entry per cycle
//   RESP  | one-cycle response for a completed swap
module pop_stack_arbiter #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input logic                clk,
  input logic                reset,
  pop_stack_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [1:0] {IDLE, SWAP, RESP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q   [DEPTH];
  logic [WIDTH-1:0] main_d   [DEPTH];
  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [WIDTH-1:0] shadow_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    shadow_count_q, shadow_count_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             last_q, last_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  logic             grant_a, grant_b;
  logic             a_ready, b_ready, busy;
  logic             full, empty;
  logic             acc, acc_id;
  logic [1:0]       acc_op;
  logic [WIDTH-1:0] acc_data;
  logic [IW-1:0]    push_idx, top_idx;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign acc      = a_ready | b_ready;
  assign acc_id   = b_ready;
  assign acc_op   = b_ready ? bus.b_op : bus.a_op;
  assign acc_data = b_ready ? bus.b_data : bus.a_data;
  assign push_idx = IW'(count_q);
  assign top_idx  = IW'(count_q - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc && acc_op == OP_SWAP) state_d = SWAP;
      SWAP:    if (idx_q == LAST_IDX) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_q = 1 means B was served most recently, so A wins a tie
  always_comb begin
    grant_a = bus.a_valid && (!bus.b_valid || last_q);
    grant_b = bus.b_valid && (!bus.a_valid || !last_q);
    a_ready = (state_q == IDLE) && grant_a;
    b_ready = (state_q == IDLE) && grant_b;
    busy    = (state_q != IDLE);
  end

  always_comb begin
    main_d         = main_q;
    shadow_d       = shadow_q;
    count_d        = count_q;
    shadow_count_d = shadow_count_q;
    idx_d          = idx_q;
    last_d         = last_q;
    resp_valid_d   = 1'b0;
    resp_id_d      = resp_id_q;
    resp_data_d    = '0;
    resp_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          last_d    = acc_id;
          resp_id_d = acc_id;
          case (acc_op)
            OP_PUSH: begin
              resp_valid_d = 1'b1;
              if (full) begin
                resp_err_d = 1'b1;
              end else begin
                main_d[push_idx] = acc_data;
                count_d          = count_q + CW'(1);
              end
            end
            OP_POP: begin
              resp_valid_d = 1'b1;
              if (empty) begin
                resp_err_d = 1'b1;
              end else begin
                resp_data_d     = main_q[top_idx];
                main_d[top_idx] = '0;
                count_d         = count_q - CW'(1);
              end
            end
            OP_SWAP: idx_d = '0;
            default: begin
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
            end
          endcase
        end
      end
      SWAP: begin
        main_d[idx_q]   = shadow_q[idx_q];
        shadow_d[idx_q] = main_q[idx_q];
        idx_d           = idx_q + IW'(1);
        // resp_id_q still holds the swap requester captured at acceptance
        if (idx_q == LAST_IDX) begin
          idx_d          = '0;
          count_d        = shadow_count_q;
          shadow_count_d = count_q;
          resp_valid_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      count_q        <= '0;
      shadow_count_q <= '0;
      idx_q          <= '0;
      last_q         <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_data_q    <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      main_q         <= main_d;
      shadow_q       <= shadow_d;
      count_q        <= count_d;
      shadow_count_q <= shadow_count_d;
      idx_q          <= idx_d;
      last_q         <= last_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_data_q    <= resp_data_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign bus.a_ready      = a_ready;
  assign bus.b_ready      = b_ready;
  assign bus.busy         = busy;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.shadow_count = shadow_count_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_err     = resp_err_q;
endmodule

// File: tb/tb_pop_stack_arbiter.sv
// Bench for pop_stack_arbiter: queue-based stack model checked every cycle, plus directed literal checks.
module tb_pop_stack_arbiter;
  localparam int DEPTH = 4;
  localparam int WIDTH = 3;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pop_stack_arbiter_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  pop_stack_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic who, input logic v, input logic [1:0] op, input logic [2:0] d);
    if (who) begin
      bus.b_valid = v; bus.b_op = op; bus.b_data = d;
    end else begin
      bus.a_valid = v; bus.a_op = op; bus.a_data = d;
    end
  endtask

  // Stack model: queues hold only the occupied entries; a swap simply exchanges the queues.
  logic [2:0] m_main[$];
  logic [2:0] m_shadow[$];
  logic [2:0] m_tmp[$];
  int         m_busy_left;
  logic       m_last, p_v, p_id, p_err;
  logic [2:0] p_data;

  initial begin
    logic       win_a, win_b, nv, nerr, id;
    logic [2:0] nd, d;
    logic [1:0] op;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_main.delete(); m_shadow.delete();
        m_busy_left = 0; m_last = 1'b1; p_v = 1'b0; p_id = 1'b0; p_err = 1'b0; p_data = '0;
      end else begin
        win_a = 1'b0; win_b = 1'b0;
        if (m_busy_left == 0) begin
          if (bus.a_valid && bus.b_valid) begin
            win_a = m_last; win_b = !m_last;
          end else begin
            win_a = bus.a_valid; win_b = bus.b_valid;
          end
        end
        check("a_ready", bus.a_ready, win_a);
        check("b_ready", bus.b_ready, win_b);
        check("busy", bus.busy, m_busy_left != 0);
        check("count", bus.count, m_main.size());
        check("shadow_count", bus.shadow_count, m_shadow.size());
        check("full", bus.full, m_main.size() == DEPTH);
        check("empty", bus.empty, m_main.size() == 0);
        check("resp_valid", bus.resp_valid, p_v);
        if (p_v) begin
          check("resp_id", bus.resp_id, p_id);
          check("resp_data", bus.resp_data, p_data);
          check("resp_err", bus.resp_err, p_err);
        end
        nv = 1'b0; nerr = 1'b0; nd = '0;
        if (m_busy_left != 0) begin
          m_busy_left--;
          if (m_busy_left == 1) begin
            m_tmp = m_main; m_main = m_shadow; m_shadow = m_tmp;
            nv = 1'b1;
          end
        end else if (win_a || win_b) begin
          id = win_b;
          m_last = id;
          p_id = id;
          op = id ? bus.b_op : bus.a_op;
          d  = id ? bus.b_data : bus.a_data;
          case (op)
            OP_PUSH: begin
              nv = 1'b1;
              if (m_main.size() < DEPTH) m_main.push_back(d);
              else nerr = 1'b1;
            end
            OP_POP: begin
              nv = 1'b1;
              if (m_main.size() > 0) nd = m_main.pop_back();
              else nerr = 1'b1;
            end
            OP_SWAP: m_busy_left = DEPTH + 1;
            default: begin nv = 1'b1; nerr = 1'b1; end
          endcase
        end
        p_v = nv; p_err = nerr; p_data = nd;
      end
    end
  end

  task automatic req(input logic who, input logic [1:0] op, input logic [2:0] d,
                     output logic rv, output logic [2:0] rdata, output logic rerr);
    logic got;
    int   w;
    @(posedge clk); #1; drive(who, 1'b1, op, d);
    got = 1'b0; w = 0;
    while (!got && w < 50) begin
      @(negedge clk);
      got = who ? bus.b_ready : bus.a_ready;
      w++;
    end
    check("req_accept", got, 1);
    @(posedge clk); #1; drive(who, 1'b0, OP_NOP, 3'd0);
    @(negedge clk);
    rv = bus.resp_valid; rdata = bus.resp_data; rerr = bus.resp_err;
  endtask

  task automatic swap_measure(input logic who, output int busy_n, output int resp_at);
    logic got;
    int   w;
    @(posedge clk); #1; drive(who, 1'b1, OP_SWAP, 3'd0);
    got = 1'b0; w = 0;
    while (!got && w < 50) begin
      @(negedge clk);
      got = who ? bus.b_ready : bus.a_ready;
      w++;
    end
    check("swap_accept", got, 1);
    @(posedge clk); #1; drive(who, 1'b0, OP_NOP, 3'd0);
    busy_n = 0; resp_at = 0;
    for (int k = 1; k <= DEPTH + 4; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.resp_valid && resp_at == 0) resp_at = k;
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  function automatic logic [1:0] rand_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 40) return OP_PUSH;
    if (r < 75) return OP_POP;
    if (r < 85) return OP_NOP;
    return OP_SWAP;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rv, re, got, acc_a, acc_b;
    logic [2:0] rd;
    logic [2:0] pushv [4];
    int         busy_n, resp_at, w, first, rv_seen;

    pushv[0] = 3'd5; pushv[1] = 3'd2; pushv[2] = 3'd7; pushv[3] = 3'd1;
    reset = 1'b1;
    drive(1'b0, 1'b0, OP_NOP, 3'd0);
    drive(1'b1, 1'b0, OP_NOP, 3'd0);
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;

    @(negedge clk);
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_readys", {bus.a_ready, bus.b_ready}, 0);

    for (int i = 0; i < 4; i++) begin
      req(1'b0, OP_PUSH, pushv[i], rv, rd, re);
      check("push_rv", rv, 1);
      check("push_err", re, 0);
    end
    check("full_after_4", bus.full, 1);
    req(1'b0, OP_PUSH, 3'd6, rv, rd, re);
    check("overflow_err", re, 1);
    check("overflow_count", bus.count, 4);
    for (int i = 3; i >= 0; i--) begin
      req(1'b0, OP_POP, 3'd0, rv, rd, re);
      check("pop_rv", rv, 1);
      check("pop_data", rd, pushv[i]);
    end
    req(1'b0, OP_POP, 3'd0, rv, rd, re);
    check("underflow_err", re, 1);
    check("underflow_data", rd, 0);

    reset_pulse();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_PUSH, 3'd3);
    drive(1'b1, 1'b1, OP_PUSH, 3'd4);
    @(negedge clk);
    check("tie_a_first", {bus.a_ready, bus.b_ready}, 2'b10);
    @(posedge clk); #1; drive(1'b0, 1'b0, OP_NOP, 3'd0);
    @(negedge clk);
    check("tie_b_next", {bus.a_ready, bus.b_ready}, 2'b01);
    check("tie_resp_a", {bus.resp_valid, bus.resp_id}, 2'b10);
    @(posedge clk); #1; drive(1'b1, 1'b0, OP_NOP, 3'd0);
    @(negedge clk);
    check("tie_resp_b", {bus.resp_valid, bus.resp_id}, 2'b11);
    req(1'b0, OP_POP, 3'd0, rv, rd, re);
    check("tie_top", rd, 4);

    reset_pulse();
    req(1'b0, OP_PUSH, 3'd6, rv, rd, re);
    req(1'b0, OP_PUSH, 3'd1, rv, rd, re);
    swap_measure(1'b0, busy_n, resp_at);
    check("swap_busy_cycles", busy_n, DEPTH + 1);
    check("swap_resp_cycle", resp_at, DEPTH + 1);
    check("swap_count", bus.count, 0);
    check("swap_shadow_count", bus.shadow_count, 2);
    swap_measure(1'b1, busy_n, resp_at);
    req(1'b0, OP_POP, 3'd0, rv, rd, re);
    check("swap_back_pop", rd, 1);

    @(posedge clk); #1; drive(1'b0, 1'b1, OP_SWAP, 3'd0);
    got = 1'b0; w = 0;
    while (!got && w < 50) begin @(negedge clk); got = bus.a_ready; w++; end
    check("swap_wait_accept", got, 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_NOP, 3'd0);
    drive(1'b1, 1'b1, OP_POP, 3'd0);
    first = 0;
    for (int k = 1; k <= DEPTH + 6 && first == 0; k++) begin
      @(negedge clk);
      if (bus.b_ready) first = k;
    end
    check("b_wait_cycles", first, DEPTH + 2);
    @(posedge clk); #1; drive(1'b1, 1'b0, OP_NOP, 3'd0);

    reset_pulse();
    req(1'b0, OP_PUSH, 3'd3, rv, rd, re);
    req(1'b0, OP_PUSH, 3'd5, rv, rd, re);
    @(posedge clk); #1; drive(1'b0, 1'b1, OP_SWAP, 3'd0);
    got = 1'b0; w = 0;
    while (!got && w < 50) begin @(negedge clk); got = bus.a_ready; w++; end
    check("abort_accept", got, 1);
    @(posedge clk); #1; drive(1'b0, 1'b0, OP_NOP, 3'd0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("abort_count", bus.count, 0);
    check("abort_shadow_count", bus.shadow_count, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_empty", bus.empty, 1);
    rv_seen = 0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      if (bus.resp_valid) rv_seen++;
      @(negedge clk);
    end
    check("abort_no_resp", rv_seen, 0);

    acc_a = 1'b0; acc_b = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      @(posedge clk); #1;
      if (!bus.a_valid || acc_a) begin
        if ($urandom_range(0, 2) != 0) drive(1'b0, 1'b1, rand_op(), 3'($urandom_range(0, 7)));
        else drive(1'b0, 1'b0, OP_NOP, 3'd0);
      end
      if (!bus.b_valid || acc_b) begin
        if ($urandom_range(0, 2) != 0) drive(1'b1, 1'b1, rand_op(), 3'($urandom_range(0, 7)));
        else drive(1'b1, 1'b0, OP_NOP, 3'd0);
      end
      reset = ($urandom_range(0, 299) == 0);
    end

    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, OP_NOP, 3'd0);
    drive(1'b1, 1'b0, OP_NOP, 3'd0);
    repeat (DEPTH + 4) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
